// File: rtl/multdiv_pkg.sv
// Shared op codes, controller states and datapath step modes for the HI/LO multiply/divide unit.
package multdiv_pkg;

    localparam int ITER = 32;

    localparam logic [3:0] MULT  = 4'd0;
    localparam logic [3:0] MULTU = 4'd1;
    localparam logic [3:0] DIV   = 4'd2;
    localparam logic [3:0] DIVU  = 4'd3;
    localparam logic [3:0] MTHI  = 4'd4;
    localparam logic [3:0] MTLO  = 4'd5;
    localparam logic [3:0] MFHI  = 4'd6;
    localparam logic [3:0] MFLO  = 4'd7;
    localparam logic [3:0] MADD  = 4'd8;
    localparam logic [3:0] MADDU = 4'd9;

    typedef enum logic [1:0] {IDLE, CALC, FIX, ACC} state_t;

    typedef enum logic {STEP_MUL, STEP_DIV} step_mode_t;

    function automatic logic is_mf(input logic [3:0] op);
        return (op == MFHI) || (op == MFLO);
    endfunction

    function automatic logic is_madd(input logic [3:0] op);
        return (op == MADD) || (op == MADDU);
    endfunction

endpackage

// File: rtl/multdiv_step.sv
// One iteration of the shared datapath: a radix-2 Booth step or a restoring-divide step.
module multdiv_step
    import multdiv_pkg::*;
#(
    parameter int WIDTH = ITER
) (
    input  step_mode_t       mode,
    input  logic             last,
    input  logic             is_signed,
    input  logic [WIDTH:0]   a_in,
    input  logic [WIDTH:0]   m_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic             qn_in,
    output logic [WIDTH:0]   a_out,
    output logic [WIDTH-1:0] q_out,
    output logic             qn_out
);
    logic [WIDTH+1:0] a_ext;
    logic [WIDTH+1:0] m_ext;
    logic [WIDTH+1:0] sum;
    logic [WIDTH+1:0] diff;
    logic [WIDTH:0]   shifted;
    logic             unsigned_top;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        a_ext        = {a_in[WIDTH], a_in};
        m_ext        = {m_in[WIDTH], m_in};
        sum          = a_ext;
        diff         = '0;
        shifted      = '0;
        a_out        = a_in;
        q_out        = q_in;
        qn_out       = qn_in;
        unsigned_top = last && !is_signed;

        if (mode == STEP_MUL) begin
            // The final unsigned step weighs the multiplier MSB as +2^31 instead of -2^31,
            // turning the Booth digit into Q[0]+Qn (0, 1 or 2).
            case ({q_in[0], qn_in})
                2'b01:   sum = a_ext + m_ext;
                2'b10:   sum = unsigned_top ? a_ext + m_ext : a_ext - m_ext;
                2'b11:   sum = unsigned_top ? a_ext + (m_ext << 1) : a_ext;
                default: sum = a_ext;
            endcase
            a_out  = sum[WIDTH+1:1];
            q_out  = {sum[0], q_in[WIDTH-1:1]};
            qn_out = q_in[0];
        end else begin
            shifted = {a_in[WIDTH-1:0], q_in[WIDTH-1]};
            diff    = {1'b0, shifted} - {1'b0, m_in};
            if (!diff[WIDTH+1]) begin
                a_out = diff[WIDTH:0];
                q_out = {q_in[WIDTH-2:0], 1'b1};
            end else begin
                a_out = shifted;
                q_out = {q_in[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/multdiv_ctrl.sv
// HI/LO multiply/divide sequencer: 32-step Booth multiply, restoring divide, MTHI/MTLO/MFHI/MFLO.
// Define MULTDIV_MADD_EN to add MADD/MADDU, which accumulate the product into {hi,lo} via ACC.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int WIDTH = ITER,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             op_valid,
    input  logic [3:0]       op_code,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             op_ready,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    state_t           state;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   acc;    // Booth accumulator, or partial remainder when dividing
    logic [WIDTH-1:0] quo;    // multiplier, or dividend shifting into quotient
    logic             qn;
    logic [WIDTH:0]   mcand;  // multiplicand, or divisor magnitude
    logic             is_div;
    logic             is_signed;
    logic             is_madd_op;
    logic             div_zero;
    logic             neg_quo;
    logic             neg_rem;

    logic             accept;
    logic             last;
    logic             mul_op;
    logic             mul_signed;
    logic             madd_op;
    logic             div_op;
    logic             rs_neg;
    logic             rt_neg;
    logic [WIDTH-1:0] rs_mag;
    logic [WIDTH-1:0] rt_mag;
    step_mode_t       step_mode;
    logic [WIDTH:0]   step_acc;
    logic [WIDTH-1:0] step_quo;
    logic             step_qn;

`ifdef MULTDIV_MADD_EN
    assign madd_op = is_madd(op_code);
`else
    assign madd_op = 1'b0;
`endif

    assign op_ready   = (state == IDLE);
    assign accept     = op_valid && op_ready;
    assign stall      = op_valid && !op_ready;
    assign last       = (count == CNT_W'(WIDTH - 1));
    assign mul_op     = (op_code == MULT) || (op_code == MULTU) || madd_op;
    assign mul_signed = (op_code == MULT) || (op_code == MADD);
    assign div_op     = (op_code == DIV) || (op_code == DIVU);
    assign rs_neg     = (op_code == DIV) && rs_val[WIDTH-1];
    assign rt_neg     = (op_code == DIV) && rt_val[WIDTH-1];
    assign rs_mag     = rs_neg ? -rs_val : rs_val;
    assign rt_mag     = rt_neg ? -rt_val : rt_val;
    assign step_mode  = is_div ? STEP_DIV : STEP_MUL;

    always_comb begin
        result_valid = accept && is_mf(op_code);
        result       = '0;
        if (result_valid) begin
            result = (op_code == MFHI) ? hi : lo;
        end
    end

    multdiv_step #(.WIDTH(WIDTH)) u_step (
        .mode      (step_mode),
        .last      (last),
        .is_signed (is_signed),
        .a_in      (acc),
        .m_in      (mcand),
        .q_in      (quo),
        .qn_in     (qn),
        .a_out     (step_acc),
        .q_out     (step_quo),
        .qn_out    (step_qn)
    );

    // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (rst) begin
                state      <= IDLE;
                busy       <= 1'b0;
                count      <= '0;
                hi         <= '0;
                lo         <= '0;
                acc        <= '0;
                quo        <= '0;
                qn         <= 1'b0;
                mcand      <= '0;
                is_div     <= 1'b0;
                is_signed  <= 1'b0;
                is_madd_op <= 1'b0;
                div_zero   <= 1'b0;
                neg_quo    <= 1'b0;
                neg_rem    <= 1'b0;
            end else if (flush) begin
                state <= IDLE;
                busy  <= 1'b0;
                count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept && mul_op) begin
                            state      <= CALC;
                            busy       <= 1'b1;
                            count      <= '0;
                            acc        <= '0;
                            quo        <= rt_val;
                            qn         <= 1'b0;
                            mcand      <= mul_signed ? {rs_val[WIDTH-1], rs_val} : {1'b0, rs_val};
                            is_div     <= 1'b0;
                            is_signed  <= mul_signed;
                            is_madd_op <= madd_op;
                            div_zero   <= 1'b0;
                        end else if (accept && div_op) begin
                            // A zero divisor keeps the raw dividend so it can land in HI.
                            state      <= CALC;
                            busy       <= 1'b1;
                            count      <= '0;
                            acc        <= '0;
                            quo        <= (rt_val == '0) ? rs_val : rs_mag;
                            qn         <= 1'b0;
                            mcand      <= {1'b0, rt_mag};
                            is_div     <= 1'b1;
                            is_signed  <= (op_code == DIV);
                            is_madd_op <= 1'b0;
                            div_zero   <= (rt_val == '0);
                            neg_quo    <= rs_neg ^ rt_neg;
                            neg_rem    <= rs_neg;
                        end else if (accept && op_code == MTHI) begin
                            hi <= rs_val;
                        end else if (accept && op_code == MTLO) begin
                            lo <= rs_val;
                        end
                    end
                    CALC: begin
                        if (div_zero) begin
                            hi    <= quo;
                            lo    <= '1;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            acc   <= step_acc;
                            quo   <= step_quo;
                            qn    <= step_qn;
                            count <= count + 1'b1;
                            if (last) begin
                                count <= '0;
                                if (is_div && is_signed) begin
                                    state <= FIX;
                                end else if (is_madd_op) begin
                                    state <= ACC;
                                end else begin
                                    hi    <= step_acc[WIDTH-1:0];
                                    lo    <= step_quo;
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end
                            end
                        end
                    end
                    FIX: begin
                        lo    <= neg_quo ? -quo : quo;
                        hi    <= neg_rem ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
`ifdef MULTDIV_MADD_EN
                    ACC: begin
                        {hi, lo} <= {hi, lo} + {acc[WIDTH-1:0], quo};
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end
`endif
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Bench for multdiv_ctrl: directed cases plus random traffic, checked every cycle against an
// arithmetic model that tracks HI/LO, the busy countdown and the pending result of each operation.
module tb_multdiv_ctrl;
    import multdiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        op_valid;
    logic [3:0]  op_code;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        op_ready;
    logic        stall;
    logic        busy;
    logic [31:0] result;
    logic        result_valid;
    logic [31:0] hi;
    logic [31:0] lo;

    int          tests = 0;
    int          fails = 0;

    // Model: architectural HI/LO, cycles left until the in-flight op retires, and its outcome.
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    int          m_left;

    always #5 clk = ~clk;

    multdiv_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .op_valid     (op_valid),
        .op_code      (op_code),
        .rs_val       (rs_val),
        .rt_val       (rt_val),
        .flush        (flush),
        .op_ready     (op_ready),
        .stall        (stall),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .hi           (hi),
        .lo           (lo)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare();
        logic        exp_ready;
        logic        exp_rv;
        logic [31:0] exp_res;
        exp_ready = (m_left == 0);
        exp_rv    = op_valid && exp_ready && (op_code == MFHI || op_code == MFLO);
        exp_res   = !exp_rv ? 32'd0 : (op_code == MFHI) ? m_hi : m_lo;
        check("op_ready", 64'(op_ready), 64'(exp_ready));
        check("stall", 64'(stall), 64'(op_valid && !exp_ready));
        check("busy", 64'(busy), 64'(!exp_ready));
        check("result_valid", 64'(result_valid), 64'(exp_rv));
        check("result", 64'(result), 64'(exp_res));
        check("hi", 64'(hi), 64'(m_hi));
        check("lo", 64'(lo), 64'(m_lo));
    endtask

    task automatic model_accept();
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] prod;
        sa = longint'($signed(rs_val));
        sb = longint'($signed(rt_val));
        case (op_code)
            MULT: begin
                prod = 64'(sa * sb);
                {p_hi, p_lo} = prod;
                m_left = 32;
            end
            MULTU: begin
                prod = {32'd0, rs_val} * {32'd0, rt_val};
                {p_hi, p_lo} = prod;
                m_left = 32;
            end
            DIV, DIVU: begin
                if (rt_val == 32'd0) begin
                    p_hi   = rs_val;
                    p_lo   = 32'hFFFF_FFFF;
                    m_left = 1;
                end else if (op_code == DIV) begin
                    q      = sa / sb;
                    r      = sa % sb;
                    p_lo   = q[31:0];
                    p_hi   = r[31:0];
                    m_left = 33;
                end else begin
                    p_lo   = rs_val / rt_val;
                    p_hi   = rs_val % rt_val;
                    m_left = 32;
                end
            end
            MTHI: m_hi = rs_val;
            MTLO: m_lo = rs_val;
`ifdef MULTDIV_MADD_EN
            MADD: begin
                prod = {m_hi, m_lo} + 64'(sa * sb);
                {p_hi, p_lo} = prod;
                m_left = 33;
            end
            MADDU: begin
                prod = {m_hi, m_lo} + {32'd0, rs_val} * {32'd0, rt_val};
                {p_hi, p_lo} = prod;
                m_left = 33;
            end
`endif
            default: ;
        endcase
    endtask

    task automatic model_edge();
        if (clk_en) begin
            if (rst) begin
                m_hi   = 32'd0;
                m_lo   = 32'd0;
                m_left = 0;
            end else if (flush) begin
                m_left = 0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = p_hi;
                    m_lo = p_lo;
                end
            end else if (op_valid) begin
                model_accept();
            end
        end
    endtask

    // Inputs are set just after a rising edge; outputs are compared at the falling edge.
    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic pin(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        check({name, "_hi"}, 64'(hi), 64'(exp_hi));
        check({name, "_lo"}, 64'(lo), 64'(exp_lo));
        check({name, "_model_hi"}, 64'(m_hi), 64'(exp_hi));
        check({name, "_model_lo"}, 64'(m_lo), 64'(exp_lo));
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int cycles);
        op_valid = 1'b1;
        op_code  = op;
        rs_val   = a;
        rt_val   = b;
        tick();
        op_valid = 1'b0;
        cycles   = 0;
        while (busy === 1'b1 && cycles < 200) begin
            tick();
            cycles++;
        end
        check("op_finished", 64'(busy), 64'd0);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd1 + 32'($urandom_range(0, 9));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int stalls;
        int n;

        rst      = 1'b1;
        clk_en   = 1'b1;
        op_valid = 1'b0;
        op_code  = 4'd0;
        rs_val   = 32'd0;
        rt_val   = 32'd0;
        flush    = 1'b0;
        m_hi     = 32'd0;
        m_lo     = 32'd0;
        p_hi     = 32'd0;
        p_lo     = 32'd0;
        m_left   = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_op_ready", 64'(op_ready), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        rst = 1'b0;

        do_op(MULT, 32'hFFFF_FFFE, 32'd3, cyc);
        check("mult_busy_cycles", 64'(cyc), 64'd32);
        pin("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        do_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
        check("multu_busy_cycles", 64'(cyc), 64'd32);
        pin("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);

        do_op(DIV, 32'hFFFF_FFF9, 32'd2, cyc);
        check("div_busy_cycles", 64'(cyc), 64'd33);
        pin("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        do_op(DIVU, 32'd100, 32'd0, cyc);
        check("divu_zero_busy_cycles", 64'(cyc), 64'd1);
        pin("divu_zero", 32'd100, 32'hFFFF_FFFF);

        do_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
        check("div_ovf_busy_cycles", 64'(cyc), 64'd33);
        pin("div_ovf", 32'd0, 32'h8000_0000);

        // MFLO presented right behind a multiply must stall until the product is in LO.
        op_valid = 1'b1;
        op_code  = MULT;
        rs_val   = 32'd6;
        rt_val   = 32'd7;
        tick();
        op_code  = MFLO;
        rs_val   = 32'd0;
        rt_val   = 32'd0;
        stalls   = 0;
        n        = 0;
        #1;
        while (result_valid !== 1'b1 && n < 200) begin
            if (stall === 1'b1) stalls++;
            tick();
            #1;
            n++;
        end
        check("mflo_stall_cycles", 64'(stalls), 64'd32);
        check("mflo_result_valid", 64'(result_valid), 64'd1);
        check("mflo_result", 64'(result), 64'd42);
        tick();
        op_valid = 1'b0;

        rst = 1'b1;
        tick();
        rst = 1'b0;
        do_op(MTLO, 32'h0000_1234, 32'd0, cyc);
        check("mtlo_busy_cycles", 64'(cyc), 64'd0);
        op_valid = 1'b1;
        op_code  = MULT;
        rs_val   = 32'd2;
        rt_val   = 32'd2;
        tick();
        op_valid = 1'b0;
        repeat (10) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_op_ready", 64'(op_ready), 64'd1);
        pin("flush", 32'd0, 32'h0000_1234);

`ifdef MULTDIV_MADD_EN
        do_op(MTHI, 32'd0, 32'd0, cyc);
        do_op(MTLO, 32'd5, 32'd0, cyc);
        do_op(MADD, 32'd2, 32'd3, cyc);
        check("madd_busy_cycles", 64'(cyc), 64'd33);
        pin("madd", 32'd0, 32'd11);
`endif

        for (int i = 0; i < 4000; i++) begin
            op_valid = ($urandom_range(0, 3) != 0);
            op_code  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) op_code = 4'($urandom_range(0, 9));
            rs_val   = rnd_operand();
            rt_val   = rnd_operand();
            flush    = ($urandom_range(0, 99) == 0);
            clk_en   = ($urandom_range(0, 7) != 0);
            rst      = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst      = 1'b0;
        flush    = 1'b0;
        clk_en   = 1'b1;
        op_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
